// File: rtl/cu_pkg.sv
// cu_pkg: control-unit opcode encoding and decode helpers shared by the write-back stage.
`timescale 1ns/1ps
package cu_pkg;
  localparam int XLEN = 32;
  typedef enum logic [5:0] {
    CU_LUI, CU_AUIPC, CU_JAL, CU_JALR,
    CU_BEQ, CU_BNE, CU_BLT, CU_BGE, CU_BLTU, CU_BGEU,
    CU_LB, CU_LH, CU_LW, CU_LBU, CU_LHU, CU_SB, CU_SH, CU_SW,
    CU_ADDI, CU_SLTI, CU_SLTIU, CU_SLIU, CU_XORI, CU_ORI, CU_ANDI, CU_SLLI, CU_SRLI, CU_SRAI,
    CU_ADD, CU_SUB, CU_SLL, CU_SLT, CU_SLTU, CU_XOR, CU_SRL, CU_SRA, CU_OR, CU_AND,
    CU_ERROR
  } cuOPType;
  function automatic logic is_load(logic [5:0] op);
    return op >= CU_LB && op <= CU_LHU;
  endfunction
  function automatic logic is_slt(logic [5:0] op);
    return op == CU_SLT || op == CU_SLTI || op == CU_SLTU || op == CU_SLTIU;
  endfunction
  // Branches, stores, ERROR and the unused codes above it never write rd.
  function automatic logic writes_rd(logic [5:0] op);
    return op <= CU_JALR || is_load(op) || (op >= CU_ADDI && op <= CU_AND);
  endfunction
endpackage

// File: rtl/write_to_reg_load_extend.sv
// load_extend: sign/zero extension of the low byte or halfword of a loaded word.
`timescale 1ns/1ps
module load_extend
  import cu_pkg::*;
(
  input  logic [5:0]  cuOP,
  input  logic [31:0] memload,
  output logic [31:0] ld_val
);
  always_comb begin
    ld_val = cuOP == CU_LB  ? {{24{memload[7]}}, memload[7:0]} :
             cuOP == CU_LH  ? {{16{memload[15]}}, memload[15:0]} :
             cuOP == CU_LBU ? {24'b0, memload[7:0]} :
             cuOP == CU_LHU ? {16'b0, memload[15:0]} :
             memload;
  end
endmodule

// File: rtl/write_to_reg.sv
// write_to_reg: RV32I write-back select with combinational rd value/enable and a registered trace copy.
`timescale 1ns/1ps
module write_to_reg
  import cu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            nRst,
  input  logic [5:0]      cuOP,
  input  logic [XLEN-1:0] memload,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] aluOut,
  input  logic [XLEN-1:0] imm,
  input  logic            negative,
  output logic [XLEN-1:0] writeData,
  output logic            regWrite,
  output logic [XLEN-1:0] writeData_q,
  output logic            regWrite_q
);
  logic [XLEN-1:0] w_ld;
  logic [XLEN-1:0] w_upper;
  load_extend u_load_extend (
    .cuOP    (cuOP),
    .memload (memload),
    .ld_val  (w_ld)
  );
  // Masking keeps the whole imm bus in use; only [31:12] reaches the result.
  assign w_upper = imm & 32'hFFFF_F000;
  always_comb begin
    writeData = cuOP == CU_LUI                    ? w_upper :
                cuOP == CU_AUIPC                  ? w_upper + pc :
                cuOP == CU_JAL || cuOP == CU_JALR ? pc + 32'd4 :
                is_load(cuOP)                     ? w_ld :
                is_slt(cuOP)                      ? {31'b0, negative} :
                aluOut;
    regWrite = writes_rd(cuOP);
  end
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      writeData_q <= '0;
      regWrite_q  <= 1'b0;
    end else begin
      writeData_q <= writeData;
      regWrite_q  <= regWrite;
    end
  end
endmodule

// File: tb/tb_write_to_reg.sv
// tb_write_to_reg: directed checks of the write-back select and its registered copy.
`timescale 1ns/1ps
module tb_write_to_reg;
  import cu_pkg::*;
  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic [5:0]  cuOP = CU_ADD;
  logic [31:0] memload = '0, pc = '0, aluOut = '0, imm = '0;
  logic        negative = 1'b0;
  logic [31:0] writeData, writeData_q;
  logic        regWrite, regWrite_q;
  int checks = 0;
  int failures = 0;
  write_to_reg #(.XLEN(32)) dut (
    .clk(clk), .nRst(nRst), .cuOP(cuOP), .memload(memload), .pc(pc),
    .aluOut(aluOut), .imm(imm), .negative(negative),
    .writeData(writeData), .regWrite(regWrite),
    .writeData_q(writeData_q), .regWrite_q(regWrite_q)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic [5:0] op, input logic [31:0] m, input logic [31:0] p,
                       input logic [31:0] a, input logic [31:0] i, input logic n);
    cuOP = op; memload = m; pc = p; aluOut = a; imm = i; negative = n;
    #1;
  endtask
  initial begin
    @(posedge clk); #1;
    chk("rst_wd_q", writeData_q, 32'h0);
    chk("rst_rw_q", {31'b0, regWrite_q}, 32'h0);
    nRst = 1'b1;
    drive(CU_LB, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'h0, 32'h0, 1'b0);
    chk("lb", writeData, 32'hFFFFFFAA);
    chk("lb_rw", {31'b0, regWrite}, 32'h1);
    drive(CU_LBU, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'h0, 32'h0, 1'b0);
    chk("lbu", writeData, 32'h000000AA);
    chk("lbu_rw", {31'b0, regWrite}, 32'h1);
    drive(CU_LH, 32'hBBBBBABA, 32'hBBBBBBBB, 32'h0, 32'h0, 1'b0);
    chk("lh", writeData, 32'hFFFFBABA);
    drive(CU_LHU, 32'hBBBBBBBB, 32'hBBBBBBBB, 32'h0, 32'h0, 1'b0);
    chk("lhu", writeData, 32'h0000BBBB);
    drive(CU_LW, 32'hABABABAB, 32'hBBBBBBBB, 32'h0, 32'h0, 1'b0);
    chk("lw", writeData, 32'hABABABAB);
    drive(CU_LB, 32'h1234567F, 32'h0, 32'h0, 32'h0, 1'b0);
    chk("lb_pos", writeData, 32'h0000007F);
    drive(CU_LUI, 32'h0, 32'hBBBBBBBB, 32'h0, 32'd10, 1'b0);
    chk("lui_small", writeData, 32'h00000000);
    chk("lui_rw", {31'b0, regWrite}, 32'h1);
    drive(CU_AUIPC, 32'h0, 32'hBBBBBBBB, 32'h0, 32'd10, 1'b0);
    chk("auipc_small", writeData, 32'hBBBBBBBB);
    drive(CU_LUI, 32'h0, 32'hBBBBBBBB, 32'h0, 32'h12345678, 1'b0);
    chk("lui", writeData, 32'h12345000);
    drive(CU_AUIPC, 32'h0, 32'hBBBBBBBB, 32'h0, 32'h12345678, 1'b0);
    chk("auipc", writeData, 32'hCDF00BBB);
    drive(CU_JAL, 32'h0, 32'hBBBBBBBB, 32'h55, 32'h0, 1'b0);
    chk("jal", writeData, 32'hBBBBBBBF);
    drive(CU_JALR, 32'h0, 32'hBBBBBBBB, 32'h55, 32'h0, 1'b0);
    chk("jalr", writeData, 32'hBBBBBBBF);
    chk("jalr_rw", {31'b0, regWrite}, 32'h1);
    drive(CU_JAL, 32'h0, 32'hFFFFFFFC, 32'h55, 32'h0, 1'b0);
    chk("jal_wrap", writeData, 32'h00000000);
    drive(CU_ADD, 32'hFFFFFFFF, 32'h10, 32'h0, 32'h0, 1'b0);
    chk("add_zero", writeData, 32'h0);
    drive(CU_XOR, 32'hFFFFFFFF, 32'h10, 32'h0, 32'h0, 1'b0);
    chk("xor_zero", writeData, 32'h0);
    drive(CU_SB, 32'hFFFFFFFF, 32'h10, 32'h0, 32'h0, 1'b0);
    chk("sb_zero", writeData, 32'h0);
    chk("sb_rw", {31'b0, regWrite}, 32'h0);
    drive(CU_ADD, 32'h0, 32'h10, 32'h1234, 32'h0, 1'b0);
    chk("add", writeData, 32'h1234);
    chk("add_rw", {31'b0, regWrite}, 32'h1);
    drive(CU_BEQ, 32'h0, 32'h10, 32'h1234, 32'h0, 1'b0);
    chk("beq_rw", {31'b0, regWrite}, 32'h0);
    chk("beq_wd", writeData, 32'h1234);
    drive(CU_SLT, 32'h0, 32'h10, 32'h1234, 32'h0, 1'b1);
    chk("slt", writeData, 32'h00000001);
    drive(CU_SLTIU, 32'h0, 32'h10, 32'h1234, 32'h0, 1'b0);
    chk("sltiu", writeData, 32'h00000000);
    drive(CU_SLIU, 32'h0, 32'h10, 32'h4321, 32'h0, 1'b1);
    chk("sliu_wd", writeData, 32'h4321);
    chk("sliu_rw", {31'b0, regWrite}, 32'h1);
    drive(CU_SRAI, 32'h0, 32'h10, 32'h0F0F, 32'h0, 1'b1);
    chk("srai_rw", {31'b0, regWrite}, 32'h1);
    drive(CU_ERROR, 32'h0, 32'h10, 32'h9999, 32'h0, 1'b1);
    chk("error_wd", writeData, 32'h9999);
    chk("error_rw", {31'b0, regWrite}, 32'h0);
    drive(6'd50, 32'h0, 32'h10, 32'h7777, 32'h0, 1'b1);
    chk("unused_wd", writeData, 32'h7777);
    chk("unused_rw", {31'b0, regWrite}, 32'h0);
    drive(CU_SW, 32'h0, 32'h10, 32'h7777, 32'h0, 1'b1);
    chk("sw_rw", {31'b0, regWrite}, 32'h0);
    drive(CU_ADD, 32'h0, 32'h0, 32'hCAFEF00D, 32'h0, 1'b0);
    @(posedge clk); #1;
    chk("q_add_wd", writeData_q, 32'hCAFEF00D);
    chk("q_add_rw", {31'b0, regWrite_q}, 32'h1);
    #2;
    nRst = 1'b0;
    #1;
    chk("async_rst_wd", writeData_q, 32'h0);
    chk("async_rst_rw", {31'b0, regWrite_q}, 32'h0);
    drive(CU_LW, 32'hABABABAB, 32'h0, 32'h0, 32'h0, 1'b0);
    chk("rst_comb_wd", writeData, 32'hABABABAB);
    chk("rst_comb_rw", {31'b0, regWrite}, 32'h1);
    @(negedge clk);
    nRst = 1'b1;
    #1;
    chk("pre_edge_wd", writeData_q, 32'h0);
    chk("pre_edge_rw", {31'b0, regWrite_q}, 32'h0);
    @(posedge clk); #1;
    chk("post_edge_wd", writeData_q, 32'hABABABAB);
    chk("post_edge_rw", {31'b0, regWrite_q}, 32'h1);
    drive(CU_BEQ, 32'h0, 32'h0, 32'h5, 32'h0, 1'b0);
    @(posedge clk); #1;
    chk("q_beq_wd", writeData_q, 32'h5);
    chk("q_beq_rw", {31'b0, regWrite_q}, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
